// File: rtl/pad_mux_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pad_mux_ctrl
// Description : Runtime pin-mux controller. An APB register holds a 2-bit
//               function select per pad. Each pad is routed to the selected
//               peripheral's o/oe, and the pad input is returned only to that
//               peripheral. A change of function is sequenced without glitches:
//               the pads that change are tri-stated for GUARD_CYC cycles
//               before the new select is applied. Pads that do not change are
//               never disturbed.
// Ports       : clk, rst_n              clock, asynchronous active-low reset
//               PADDR..PSLVERR          APB slave (SEL @0x000, STATUS @0x004)
//               fn_o/fn_oe/fn_i         peripheral side, index p*NFUNC+f
//               pad_o/pad_oe/pad_i      io_tri cell side, one bit per pad
// Config      : PAD_MUX_LOCK_EN adds a sticky LOCK register at 0x008 that
//               blocks further SEL writes until reset.
// Revision    : 1.0 - initial release
// ============================================================================
module pad_mux_ctrl #(
    parameter int          NPADS     = 14,
    parameter int          NFUNC     = 4,
    parameter int          GUARD_CYC = 4,
    parameter logic [31:0] RESET_SEL = 32'h0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [11:0]            PADDR,
    input  logic [31:0]            PWDATA,
    input  logic                   PWRITE,
    input  logic                   PSEL,
    input  logic                   PENABLE,
    output logic [31:0]            PRDATA,
    output logic                   PREADY,
    output logic                   PSLVERR,
    input  logic [NPADS*NFUNC-1:0] fn_o,
    input  logic [NPADS*NFUNC-1:0] fn_oe,
    output logic [NPADS*NFUNC-1:0] fn_i,
    output logic [NPADS-1:0]       pad_o,
    output logic [NPADS-1:0]       pad_oe,
    input  logic [NPADS-1:0]       pad_i
);

    localparam int          c_SW          = 2 * NPADS;
    localparam logic [11:0] c_ADDR_SEL    = 12'h000;
    localparam logic [11:0] c_ADDR_STATUS = 12'h004;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DRAIN  = 2'd1,
        S_SWITCH = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [c_SW-1:0]   r_sel;
    logic [c_SW-1:0]   r_new;
    logic [c_SW-1:0]   w_new;
    logic [NPADS-1:0]  r_mask;
    logic [NPADS-1:0]  w_chg;
    logic [7:0]        r_cnt;
    logic              w_access;
    logic              w_hit_sel;
    logic              w_hit_status;
    logic              w_hit_lock;
    logic              w_addr_ok;
    logic              w_locked;
    logic              w_sel_wr;
    logic              w_start;
    logic              w_busy;
    logic [31:0]       w_sel_rd;
    logic              w_unused_pwdata;

    assign w_access     = PSEL & PENABLE;
    assign w_hit_sel    = (PADDR == c_ADDR_SEL);
    assign w_hit_status = (PADDR == c_ADDR_STATUS);
    assign w_new        = PWDATA[c_SW-1:0];
    assign w_busy       = (r_state != S_IDLE);
    // Upper PWDATA bits beyond the select field are intentionally ignored.
    assign w_unused_pwdata = ^PWDATA;

`ifdef PAD_MUX_LOCK_EN
    localparam logic [11:0] c_ADDR_LOCK = 12'h008;
    logic r_lock;

    assign w_hit_lock = (PADDR == c_ADDR_LOCK);
    assign w_locked   = r_lock;

    // The bus is held by a pending SEL write while the FSM is busy, so a lock
    // write can only be accepted in IDLE, i.e. after any SWITCH completed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lock <= 1'b0;
        end else if (w_access && PWRITE && w_hit_lock && PWDATA[0] && (r_state == S_IDLE)) begin
            r_lock <= 1'b1;
        end
    end
`else
    assign w_hit_lock = 1'b0;
    assign w_locked   = 1'b0;
`endif

    assign w_addr_ok = w_hit_sel | w_hit_status | w_hit_lock;
    assign w_sel_wr  = w_access & PWRITE & w_hit_sel & ~w_locked;
    assign w_start   = (r_state == S_IDLE) & w_sel_wr & (|w_chg);

    // Pads whose select field differs between the write data and the
    // currently applied select.
    always_comb begin
        w_chg = '0;
        for (int p = 0; p < NPADS; p++) begin
            w_chg[p] = (w_new[2*p +: 2] != r_sel[2*p +: 2]);
        end
    end

    // ------------------------------------------------------------------
    // Sequencing FSM
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        PREADY      = 1'b1;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_state_nxt = S_DRAIN;
                    PREADY      = 1'b0;
                end
            end
            S_DRAIN: begin
                PREADY = 1'b0;
                if (r_cnt == 8'd0) begin
                    w_state_nxt = S_SWITCH;
                end
            end
            S_SWITCH: begin
                // PREADY stays high here to complete the held write.
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_sel   <= RESET_SEL[c_SW-1:0];
            r_new   <= RESET_SEL[c_SW-1:0];
            r_mask  <= '0;
            r_cnt   <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_new  <= w_new;
                        r_mask <= w_chg;
                        r_cnt  <= 8'(GUARD_CYC - 1);
                    end
                end
                S_DRAIN: begin
                    if (r_cnt != 8'd0) begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                S_SWITCH: begin
                    r_sel  <= r_new;
                    r_mask <= '0;
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // APB response
    // ------------------------------------------------------------------
    always_comb begin
        w_sel_rd             = '0;
        w_sel_rd[c_SW-1:0]   = r_sel;
    end

    assign PSLVERR = w_access & (~w_addr_ok | (PWRITE & w_hit_sel & w_locked));

    always_comb begin
        PRDATA = '0;
        if (PSEL && !PWRITE) begin
            if (w_hit_sel) begin
                PRDATA = w_sel_rd;
            end else if (w_hit_status) begin
                PRDATA[0] = w_busy;
            end
`ifdef PAD_MUX_LOCK_EN
            else if (w_hit_lock) begin
                PRDATA[0] = r_lock;
            end
`endif
        end
    end

    // ------------------------------------------------------------------
    // Pad datapath. A select value with no matching function (NFUNC < 4)
    // leaves the pad undriven and returns nothing. Masked pads keep the old
    // function on pad_o but have oe and the input return forced low.
    // Everything is held quiet while reset is asserted.
    // ------------------------------------------------------------------
    always_comb begin
        pad_o  = '0;
        pad_oe = '0;
        fn_i   = '0;
        if (rst_n) begin
            for (int p = 0; p < NPADS; p++) begin
                for (int f = 0; f < NFUNC; f++) begin
                    if (r_sel[2*p +: 2] == 2'(f)) begin
                        pad_o[p]          = fn_o[p*NFUNC + f];
                        pad_oe[p]         = fn_oe[p*NFUNC + f] & ~r_mask[p];
                        fn_i[p*NFUNC + f] = pad_i[p] & ~r_mask[p];
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pad_mux_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pad_mux_ctrl
// Description : Self-checking bench for pad_mux_ctrl with a behavioural model
//               of the select register and pad routing.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pad_mux_ctrl;

    localparam int          NPADS = 14;
    localparam int          NFUNC = 4;
    localparam int          GUARD = 4;
    localparam int          FW    = NPADS * NFUNC;
    localparam logic [31:0] RSEL  = 32'h0;
    localparam logic [31:0] SMASK = 32'h0FFF_FFFF;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [11:0]      PADDR = '0;
    logic [31:0]      PWDATA = '0;
    logic             PWRITE = 1'b0;
    logic             PSEL = 1'b0;
    logic             PENABLE = 1'b0;
    logic [31:0]      PRDATA;
    logic             PREADY;
    logic             PSLVERR;
    logic [FW-1:0]    fn_o = '0;
    logic [FW-1:0]    fn_oe = '0;
    logic [FW-1:0]    fn_i;
    logic [NPADS-1:0] pad_o;
    logic [NPADS-1:0] pad_oe;
    logic [NPADS-1:0] pad_i = '0;

    int          n_pass  = 0;
    int          n_total = 0;
    logic [31:0] m_sel;

    always #5 clk = ~clk;

    pad_mux_ctrl #(
        .NPADS(NPADS), .NFUNC(NFUNC), .GUARD_CYC(GUARD), .RESET_SEL(RSEL)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
        .fn_o(fn_o), .fn_oe(fn_oe), .fn_i(fn_i),
        .pad_o(pad_o), .pad_oe(pad_oe), .pad_i(pad_i)
    );

    // Reference routing: pad p follows function ((sel >> 2p) & 3); a masked
    // pad is tri-stated and returns nothing.
    task automatic model(input logic [31:0] sel, input logic [NPADS-1:0] msk,
                         output logic [NPADS-1:0] e_o, output logic [NPADS-1:0] e_oe,
                         output logic [FW-1:0] e_fi);
        e_o = '0; e_oe = '0; e_fi = '0;
        for (int p = 0; p < NPADS; p++) begin
            int s;
            s = int'((sel >> (2 * p)) & 32'd3);
            if (s < NFUNC) begin
                e_o[p]  = fn_o[p * NFUNC + s];
                e_oe[p] = fn_oe[p * NFUNC + s] & ~msk[p];
                if (!msk[p]) e_fi[p * NFUNC + s] = pad_i[p];
            end
        end
    endtask

    task automatic randomize_pads();
        logic [63:0] t;
        t = {$urandom, $urandom}; fn_o  = t[FW-1:0];
        t = {$urandom, $urandom}; fn_oe = t[FW-1:0];
        t = {$urandom, $urandom}; pad_i = t[NPADS-1:0];
    endtask

    task automatic apb_write(input logic [11:0] a, input logic [31:0] d,
                             output int waits, output logic err);
        @(posedge clk); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d;
        @(posedge clk); #1;
        PENABLE = 1'b1;
        waits = 0;
        @(negedge clk);
        while (!PREADY && waits < 100) begin
            waits++;
            @(negedge clk);
        end
        err = PSLVERR;
        @(posedge clk); #1;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic apb_read(input logic [11:0] a, output logic [31:0] d, output logic err);
        int waits;
        @(posedge clk); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
        @(posedge clk); #1;
        PENABLE = 1'b1;
        waits = 0;
        @(negedge clk);
        while (!PREADY && waits < 100) begin
            waits++;
            @(negedge clk);
        end
        d = PRDATA; err = PSLVERR;
        @(posedge clk); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d; logic e;
        rst_n = 1'b0; fn_oe = '1; fn_o = '1; pad_i = '1;
        repeat (3) @(negedge clk);
        n_total++;
        if (pad_oe !== '0) $display("FAIL reset_pad_oe: got %h want 0", pad_oe); else n_pass++;
        n_total++;
        if ({pad_o, fn_i} !== '0) $display("FAIL reset_pad_o_fn_i: got %h/%h want 0", pad_o, fn_i); else n_pass++;
        n_total++;
        if ({PREADY, PSLVERR, PRDATA} !== {1'b1, 1'b0, 32'h0})
            $display("FAIL reset_apb: got ready=%b err=%b rdata=%h want 1/0/0", PREADY, PSLVERR, PRDATA);
        else n_pass++;
        rst_n = 1'b1;
        m_sel = RSEL & SMASK;
        apb_read(12'h000, d, e);
        n_total++;
        if (d !== m_sel || e !== 1'b0) $display("FAIL reset_sel_read: got %h err=%b want %h", d, e, m_sel); else n_pass++;
        apb_read(12'h004, d, e);
        n_total++;
        if (d !== 32'h0) $display("FAIL reset_status: got %h want 0", d); else n_pass++;
    endtask

    task automatic test_route();
        int w; logic e;
        logic [FW-1:0] exp_fi;
        apb_write(12'h000, 32'h0, w, e);
        m_sel = 32'h0;
        fn_o = '0; fn_oe = '0; pad_i = '1; exp_fi = '0;
        for (int p = 0; p < NPADS; p++) begin
            fn_o[p * 4] = 1'b1; fn_oe[p * 4] = 1'b1; exp_fi[p * 4] = 1'b1;
        end
        @(negedge clk);
        n_total++;
        if (pad_o !== '1 || pad_oe !== '1) $display("FAIL route_out: got o=%h oe=%h want all ones", pad_o, pad_oe); else n_pass++;
        n_total++;
        if (fn_i !== exp_fi) $display("FAIL route_fn_i: got %h want %h", fn_i, exp_fi); else n_pass++;
    endtask

    task automatic test_switch();
        int low, oe2_off; logic steady_ok, drain_ok;
        logic [NPADS-1:0] e_o, e_oe; logic [FW-1:0] e_fi;
        logic [31:0] d; logic e;
        randomize_pads(); fn_oe = '1;
        @(posedge clk); #1;
        PSEL = 1'b1; PWRITE = 1'b1; PADDR = 12'h000; PWDATA = 32'h20; PENABLE = 1'b0;
        @(posedge clk); #1;
        PENABLE = 1'b1;
        low = 0; oe2_off = 0; steady_ok = 1'b1; drain_ok = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (PREADY) break;
            low++;
            if (pad_oe[2] === 1'b0) oe2_off++;
            if (pad_oe[0] !== 1'b1 || pad_o[0] !== fn_o[0]) steady_ok = 1'b0;
            if (low > 1 && (pad_oe[2] !== 1'b0 || fn_i[8] !== 1'b0 || pad_o[2] !== fn_o[8])) drain_ok = 1'b0;
        end
        n_total++;
        if (PSLVERR !== 1'b0) $display("FAIL switch_err: got %b want 0", PSLVERR); else n_pass++;
        @(posedge clk); #1;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        m_sel = 32'h20;
        n_total++;
        if (low !== GUARD + 1) $display("FAIL switch_wait: got %0d want %0d", low, GUARD + 1); else n_pass++;
        n_total++;
        if (oe2_off !== GUARD) $display("FAIL switch_guard: got %0d want %0d", oe2_off, GUARD); else n_pass++;
        n_total++;
        if (!steady_ok) $display("FAIL switch_pad0_glitch: got 0 want 1"); else n_pass++;
        n_total++;
        if (!drain_ok) $display("FAIL switch_drain_state: got 0 want 1"); else n_pass++;
        @(negedge clk);
        model(m_sel, '0, e_o, e_oe, e_fi);
        n_total++;
        if ({pad_o, pad_oe, fn_i} !== {e_o, e_oe, e_fi})
            $display("FAIL switch_after: got %h/%h/%h want %h/%h/%h", pad_o, pad_oe, fn_i, e_o, e_oe, e_fi);
        else n_pass++;
        apb_read(12'h004, d, e);
        n_total++;
        if (d !== 32'h0) $display("FAIL switch_status_after: got %h want 0", d); else n_pass++;
    endtask

    task automatic test_same();
        int w; logic e; logic [31:0] d;
        apb_write(12'h000, m_sel | 32'hF000_0000, w, e);
        n_total++;
        if (w !== 0 || e !== 1'b0) $display("FAIL same_wait: got %0d err=%b want 0/0", w, e); else n_pass++;
        apb_read(12'h000, d, e);
        n_total++;
        if (d !== m_sel) $display("FAIL same_readback: got %h want %h", d, m_sel); else n_pass++;
    endtask

    task automatic test_random();
        int w, exp_w; logic e; logic [31:0] nv, d;
        logic [NPADS-1:0] e_o, e_oe; logic [FW-1:0] e_fi;
        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 3) == 0) nv = m_sel | ($urandom & 32'hF000_0000);
            else nv = $urandom;
            exp_w = ((nv & SMASK) != m_sel) ? GUARD + 1 : 0;
            apb_write(12'h000, nv, w, e);
            m_sel = nv & SMASK;
            n_total++;
            if (w !== exp_w || e !== 1'b0) $display("FAIL rand_wait[%0d]: got %0d err=%b want %0d/0", i, w, e, exp_w); else n_pass++;
            randomize_pads();
            @(negedge clk);
            model(m_sel, '0, e_o, e_oe, e_fi);
            n_total++;
            if ({pad_o, pad_oe, fn_i} !== {e_o, e_oe, e_fi})
                $display("FAIL rand_route[%0d]: got %h/%h/%h want %h/%h/%h", i, pad_o, pad_oe, fn_i, e_o, e_oe, e_fi);
            else n_pass++;
            apb_read(12'h000, d, e);
            n_total++;
            if (d !== m_sel) $display("FAIL rand_readback[%0d]: got %h want %h", i, d, m_sel); else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        int w1, w2; logic e1, e2; logic [31:0] d, v1, v2;
        v1 = m_sel ^ 32'h0000_0003;
        v2 = v1 ^ 32'h0C00_0000;
        apb_write(12'h000, v1, w1, e1);
        apb_write(12'h000, v2, w2, e2);
        m_sel = v2;
        n_total++;
        if (w1 !== GUARD + 1 || w2 !== GUARD + 1) $display("FAIL b2b_wait: got %0d,%0d want %0d", w1, w2, GUARD + 1); else n_pass++;
        apb_read(12'h000, d, e1);
        n_total++;
        if (d !== m_sel) $display("FAIL b2b_readback: got %h want %h", d, m_sel); else n_pass++;
    endtask

    task automatic test_reset_drain();
        int w; logic e; logic [31:0] d;
        fn_oe = '1;
        @(posedge clk); #1;
        PSEL = 1'b1; PWRITE = 1'b1; PADDR = 12'h000; PWDATA = m_sel ^ 32'h1; PENABLE = 1'b0;
        @(posedge clk); #1;
        PENABLE = 1'b1;
        repeat (3) @(negedge clk);   // access cycle, then two guard cycles
        n_total++;
        if (PREADY !== 1'b0 || pad_oe !== 14'h3FFE)
            $display("FAIL drain_before_reset: got ready=%b oe=%h want 0/3ffe", PREADY, pad_oe);
        else n_pass++;
        rst_n = 1'b0;
        #1;
        n_total++;
        if ({pad_oe, pad_o, fn_i} !== '0) $display("FAIL drain_reset_quiet: got %h/%h/%h want 0", pad_oe, pad_o, fn_i); else n_pass++;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        m_sel = RSEL & SMASK;
        apb_read(12'h000, d, e);
        n_total++;
        if (d !== m_sel) $display("FAIL drain_reset_sel: got %h want %h", d, m_sel); else n_pass++;
        apb_read(12'h004, d, e);
        n_total++;
        if (d !== 32'h0) $display("FAIL drain_reset_status: got %h want 0", d); else n_pass++;
        apb_write(12'h000, 32'h0000_0300, w, e);
        m_sel = 32'h0000_0300;
        n_total++;
        if (w !== GUARD + 1) $display("FAIL drain_reset_idle: got %0d want %0d", w, GUARD + 1); else n_pass++;
    endtask

    task automatic test_decode();
        int w; logic e; logic [31:0] d;
        apb_read(12'h00C, d, e);
        n_total++;
        if (e !== 1'b1 || d !== 32'h0) $display("FAIL unmapped_00c: got err=%b d=%h want 1/0", e, d); else n_pass++;
        apb_read(12'h800, d, e);
        n_total++;
        if (e !== 1'b1 || d !== 32'h0) $display("FAIL unmapped_800: got err=%b d=%h want 1/0", e, d); else n_pass++;
        apb_write(12'h004, 32'hFFFF_FFFF, w, e);
        n_total++;
        if (e !== 1'b0 || w !== 0) $display("FAIL status_write: got err=%b waits=%0d want 0/0", e, w); else n_pass++;
        apb_read(12'h004, d, e);
        n_total++;
        if (d !== 32'h0) $display("FAIL status_after_write: got %h want 0", d); else n_pass++;
`ifdef PAD_MUX_LOCK_EN
        apb_write(12'h008, 32'h1, w, e);
        apb_read(12'h008, d, e);
        n_total++;
        if (d !== 32'h1 || e !== 1'b0) $display("FAIL lock_read: got %h err=%b want 1/0", d, e); else n_pass++;
        apb_write(12'h000, 32'h5, w, e);
        n_total++;
        if (e !== 1'b1 || w !== 0) $display("FAIL lock_sel_write: got err=%b waits=%0d want 1/0", e, w); else n_pass++;
        apb_read(12'h000, d, e);
        n_total++;
        if (d !== m_sel) $display("FAIL lock_sel_unchanged: got %h want %h", d, m_sel); else n_pass++;
`else
        apb_read(12'h008, d, e);
        n_total++;
        if (e !== 1'b1 || d !== 32'h0) $display("FAIL nolock_008_read: got err=%b d=%h want 1/0", e, d); else n_pass++;
        apb_write(12'h008, 32'h1, w, e);
        n_total++;
        if (e !== 1'b1) $display("FAIL nolock_008_write: got err=%b want 1", e); else n_pass++;
`endif
    endtask

    initial begin
        test_reset();
        test_route();
        test_switch();
        test_same();
        test_random();
        test_back_to_back();
        test_reset_drain();
        test_decode();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
